// File: rtl/mwi_running_sum_pkg.sv
// mwi_running_sum_pkg: shared defaults, accumulator width, FSM encoding and window-length clamp
package mwi_running_sum_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int OUT_W_DEF = 16;
    localparam int MAX_WIN_DEF = 32;
    localparam int SHIFT_DEF = 5;
    typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;
    function automatic int acc_w(input int data_w, input int max_win);
        return data_w + $clog2(max_win) + 1;
    endfunction
    function automatic int clamp_len(input int len, input int max_win);
        return len == 0 ? 1 : (len > max_win ? max_win : len);
    endfunction
endpackage

// File: rtl/mwi_running_sum_if.sv
// mwi_running_sum_if: sample stream in, scaled window sum and status out
interface mwi_running_sum_if import mwi_running_sum_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int MAX_WIN = MAX_WIN_DEF
) ();
    logic [$clog2(MAX_WIN):0] win_len;
    logic in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic out_valid;
    logic signed [OUT_W-1:0] out_data;
    logic out_full;
    logic out_ovf;
    modport master (output win_len, in_valid, in_data, input out_valid, out_data, out_full, out_ovf);
    modport slave (input win_len, in_valid, in_data, output out_valid, out_data, out_full, out_ovf);
endinterface

// File: rtl/mwi_ring_buffer.sv
// mwi_ring_buffer: circular sample store wrapping at the live window length, async oldest-sample read
module mwi_ring_buffer #(
    parameter int DATA_W = 16,
    parameter int MAX_WIN = 32
) (
    input logic clk,
    input logic rst,
    input logic clr,
    input logic we,
    input logic [$clog2(MAX_WIN):0] len,
    input logic signed [DATA_W-1:0] wr_data,
    output logic signed [DATA_W-1:0] rd_data
);
    localparam int AW = $clog2(MAX_WIN);
    localparam int LW = AW + 1;
    logic signed [DATA_W-1:0] mem [MAX_WIN];
    logic [AW-1:0] wp, wp_base, wp_next;
    // a restart writes its first sample at slot 0 in the same cycle
    assign wp_base = clr ? '0 : wp;
    assign wp_next = {1'b0, wp_base} == len - LW'(1) ? '0 : wp_base + AW'(1);
    assign rd_data = mem[wp];
    always_ff @(posedge clk) begin
        if (rst) wp <= '0;
        else if (we) wp <= wp_next;
        else if (clr) wp <= '0;
    end
    always_ff @(posedge clk) begin
        if (we && !rst) mem[wp_base] <= wr_data;
    end
endmodule

// File: rtl/mwi_running_sum.sv
// mwi_running_sum: moving-window integrator; define MWI_SATURATE_EN to clamp the output instead of wrapping
module mwi_running_sum import mwi_running_sum_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAX_WIN = MAX_WIN_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF
) (
    input logic clk,
    input logic rst,
    mwi_running_sum_if.slave s
);
    localparam int ACC_W = acc_w(DATA_W, MAX_WIN);
    localparam int LW = $clog2(MAX_WIN) + 1;
    localparam int EW = ACC_W > OUT_W ? ACC_W : OUT_W;
    localparam logic signed [EW-1:0] OMAX = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EW-1:0] OMIN = ~OMAX;
    state_t state, state_d;
    logic signed [ACC_W-1:0] acc, acc_d, shifted;
    logic signed [EW-1:0] wide;
    logic signed [DATA_W-1:0] oldest;
    logic [LW-1:0] l, l_req, cnt, cnt_d;
    logic [OUT_W-1:0] fit, data;
    logic restart, ovf_hit, ovf, ovf_d, valid;
    assign l_req = LW'(clamp_len(int'(s.win_len), MAX_WIN));
    assign restart = l_req != l;
    mwi_ring_buffer #(.DATA_W(DATA_W), .MAX_WIN(MAX_WIN)) u_ring (
        .clk(clk),
        .rst(rst),
        .clr(restart),
        .we(s.in_valid),
        .len(l_req),
        .wr_data(s.in_data),
        .rd_data(oldest)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            acc <= '0;
            cnt <= '0;
            l <= l_req;
            ovf <= 1'b0;
            valid <= 1'b0;
            data <= '0;
        end else begin
            state <= state_d;
            acc <= acc_d;
            cnt <= cnt_d;
            l <= l_req;
            ovf <= ovf_d;
            valid <= s.in_valid;
            if (s.in_valid) data <= fit;
        end
    end
    // a window change discards the old window; a same-cycle sample opens the new one
    always_comb begin
        state_d = restart ? FILL : state;
        cnt_d = restart ? '0 : cnt;
        acc_d = restart ? '0 : acc;
        if (s.in_valid) begin
            acc_d = acc_d + ACC_W'(s.in_data) - (state_d == RUN ? ACC_W'(oldest) : ACC_W'(0));
            if (state_d == FILL) begin
                cnt_d = cnt_d + LW'(1);
                state_d = cnt_d == l_req ? RUN : FILL;
            end
        end
    end
    always_comb begin
        shifted = acc_d >>> SHIFT;
        wide = EW'(shifted);
        ovf_hit = wide > OMAX || wide < OMIN;
`ifdef MWI_SATURATE_EN
        fit = ovf_hit ? (wide[EW-1] ? OMIN[OUT_W-1:0] : OMAX[OUT_W-1:0]) : wide[OUT_W-1:0];
`else
        fit = wide[OUT_W-1:0];
`endif
        ovf_d = (!restart && ovf) || (s.in_valid && ovf_hit);
    end
    assign s.out_valid = valid;
    assign s.out_data = data;
    assign s.out_full = state == RUN;
    assign s.out_ovf = ovf;
endmodule

// File: tb/tb_mwi_running_sum.sv
// tb_mwi_running_sum: directed vectors against hand-computed window sums (SHIFT 0 and SHIFT 2 instances)
module tb_mwi_running_sum;
    localparam int MW = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n = 0;
    int errs = 0;
    always #5 clk = ~clk;
    mwi_running_sum_if #(.DATA_W(16), .OUT_W(16), .MAX_WIN(MW)) a ();
    mwi_running_sum_if #(.DATA_W(16), .OUT_W(16), .MAX_WIN(MW)) b ();
    assign b.win_len = a.win_len;
    assign b.in_valid = a.in_valid;
    assign b.in_data = a.in_data;
    mwi_running_sum #(.DATA_W(16), .MAX_WIN(MW), .OUT_W(16), .SHIFT(0)) dut (.clk(clk), .rst(rst), .s(a.slave));
    mwi_running_sum #(.DATA_W(16), .MAX_WIN(MW), .OUT_W(16), .SHIFT(2)) dut_sh (.clk(clk), .rst(rst), .s(b.slave));
    task automatic cyc(input logic v, input int d);
        a.in_valid = v;
        a.in_data = 16'(d);
        @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic out(input string tag, input int exp, input logic full);
        chk({tag, ".valid"}, 32'(a.out_valid), 1);
        chk({tag, ".data"}, a.out_data, exp);
        chk({tag, ".full"}, 32'(a.out_full), 32'(full));
    endtask
    initial begin
        int s1[6] = '{1, 2, 3, 4, 5, 6};
        int e1[6] = '{1, 3, 6, 10, 14, 18};
        int eg[5] = '{10, 30, 60, 100, 140};
        int er[5] = '{3, 7, 12, 18, 22};
`ifdef MWI_SATURATE_EN
        int es[4] = '{32767, 32767, 32767, 32767};
`else
        int es[4] = '{32767, -2, 32765, -4};
`endif
        int eb[4] = '{8191, 16383, 24575, 32767};
        a.win_len = 4;
        a.in_valid = 1'b0;
        a.in_data = '0;
        cyc(1, 77);
        cyc(0, 0);
        chk("rst.valid", 32'(a.out_valid), 0);
        chk("rst.data", a.out_data, 0);
        chk("rst.full", 32'(a.out_full), 0);
        chk("rst.ovf", 32'(a.out_ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1, s1[i]);
            out("bb", e1[i], i >= 3);
            chk("bb.shift", b.out_data, e1[i] >>> 2);
        end
        cyc(0, 0);
        chk("idle.valid", 32'(a.out_valid), 0);
        chk("idle.hold", a.out_data, 18);
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 10 * (i + 1));
            out("gap", eg[i], i >= 3);
            for (int k = 0; k < 3; k++) begin
                cyc(0, 0);
                chk("gap.idle_valid", 32'(a.out_valid), 0);
                chk("gap.idle_data", a.out_data, eg[i]);
            end
        end
        a.win_len = 2;
        cyc(1, 7);
        out("sw7", 7, 0);
        cyc(1, 8);
        out("sw8", 15, 1);
        cyc(1, 9);
        out("sw9", 17, 1);
        a.win_len = 0;
        cyc(1, 5);
        out("l1a", 5, 1);
        chk("l1a.shift", b.out_data, 1);
        cyc(1, -3);
        out("l1b", -3, 1);
        chk("l1b.shift", b.out_data, -1);
        cyc(1, 9);
        out("l1c", 9, 1);
        chk("l1c.shift", b.out_data, 2);
        chk("l1.shift_ovf", 32'(b.out_ovf), 0);
        a.win_len = 4'(MW + 5);
        for (int i = 1; i <= 9; i++) begin
            cyc(1, i);
            out("max", i <= 8 ? i * (i + 1) / 2 : 44, i >= 8);
        end
        a.win_len = 4;
        cyc(1, 100);
        cyc(1, 200);
        rst = 1'b1;
        cyc(1, 999);
        chk("midrst.valid", 32'(a.out_valid), 0);
        chk("midrst.data", a.out_data, 0);
        chk("midrst.full", 32'(a.out_full), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1, i + 3);
            out("refill", er[i], i >= 3);
        end
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32767);
            out("sat", es[i], i >= 3);
            chk("sat.ovf", 32'(a.out_ovf), i >= 1 ? 1 : 0);
            chk("sat.shift", b.out_data, eb[i]);
            chk("sat.shift_ovf", 32'(b.out_ovf), 0);
        end
        a.win_len = 2;
        cyc(0, 0);
        chk("chg.ovf_clr", 32'(a.out_ovf), 0);
        chk("chg.full_clr", 32'(a.out_full), 0);
        chk("chg.valid", 32'(a.out_valid), 0);
        a.win_len = 4;
        cyc(1, -5);
        out("neg1", -5, 0);
        chk("neg1.shift", b.out_data, -2);
        cyc(1, -7);
        out("neg2", -12, 0);
        chk("neg2.shift", b.out_data, -3);
        chk("neg.shift_ovf", 32'(b.out_ovf), 0);
        cyc(0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end
endmodule
